// File: rtl/mainfsm_fpu_pkg.sv
// Shared encodings for the multicycle main FSM: state codes, opcode classes
// and datapath mux-select values.
package mainfsm_fpu_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    FPUEXEC  = 4'd10,
    FPUWB    = 4'd11
  } state_t;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_FPU = 2'b11;

  localparam logic [1:0] SRCA_RN     = 2'b00;
  localparam logic [1:0] SRCA_PC     = 2'b01;
  localparam logic [1:0] SRCA_ALUOUT = 2'b10;

  localparam logic [1:0] SRCB_RM     = 2'b00;
  localparam logic [1:0] SRCB_EXTIMM = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] RES_FPU       = 2'b11;

endpackage

// File: rtl/mainfsm_fpu_fpu_wait_ctr.sv
// Saturating FPU wait counter with synchronous clear, count enable and a
// terminal-count flag at MAX_WAIT-1.
module fpu_wait_ctr #(
  parameter int MAX_WAIT = 32,
  parameter int CNT_W    = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (en && (count != '1))
      count <= count + 1'b1;
  end

  assign tc = (count == CNT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/mainfsm_fpu.sv
// Multicycle main control FSM with a bounded-wait FPU execute path; emits the
// unconditioned write strobes and datapath selects as a Moore decode.
module mainfsm_fpu
  import mainfsm_fpu_pkg::*;
#(
  parameter int FPU_MAX_WAIT = 32,
  parameter int CNT_W        = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       FPUDone,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       ALUOp,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       FPUW,
  output logic       FPUStart,
  output logic       FPUTimeout,
  output logic [3:0] State
);

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] count;
  logic             tc;
  logic             in_fpu;
  logic             unused_funct;

  assign unused_funct = ^Funct[4:1];
  assign in_fpu       = (state == FPUEXEC);

  // The counter sits at zero outside FPUEXEC, so every entry starts from 0.
  fpu_wait_ctr #(
    .MAX_WAIT (FPU_MAX_WAIT),
    .CNT_W    (CNT_W)
  ) u_wait_ctr (
    .clk   (clk),
    .reset (reset),
    .clear (!in_fpu),
    .en    (in_fpu),
    .count (count),
    .tc    (tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= FETCH;
    else
      state <= next_state;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      FPUTimeout <= 1'b0;
    else if (in_fpu && tc && !FPUDone)
      FPUTimeout <= 1'b1;
  end

  always_comb begin
    next_state = FETCH;
    case (state)
      FETCH:    next_state = DECODE;
      DECODE: begin
        case (Op)
          OP_DP:   next_state = Funct[5] ? EXECUTEI : EXECUTER;
          OP_MEM:  next_state = MEMADR;
          OP_BR:   next_state = BRANCH;
          default: next_state = FPUEXEC;
        endcase
      end
      MEMADR:   next_state = Funct[0] ? MEMRD : MEMWR;
      MEMRD:    next_state = MEMWB;
      EXECUTER: next_state = ALUWB;
      EXECUTEI: next_state = ALUWB;
      // A result arriving on the last allowed cycle still wins over the abort.
      FPUEXEC: begin
        if (FPUDone)
          next_state = FPUWB;
        else if (tc)
          next_state = FETCH;
        else
          next_state = FPUEXEC;
      end
      default:  next_state = FETCH;
    endcase
  end

  always_comb begin
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = SRCA_RN;
    ALUSrcB   = SRCB_RM;
    ResultSrc = RES_ALUOUT;
    ALUOp     = 1'b0;
    NextPC    = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    Branch    = 1'b0;
    FPUW      = 1'b0;
    FPUStart  = 1'b0;
    case (state)
      FETCH: begin
        IRWrite   = 1'b1;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        NextPC    = 1'b1;
      end
      DECODE: begin
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      MEMADR:   ALUSrcB = SRCB_EXTIMM;
      MEMRD:    AdrSrc  = 1'b1;
      MEMWB: begin
        ResultSrc = RES_DATA;
        RegW      = 1'b1;
      end
      MEMWR: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
      end
      EXECUTER: ALUOp = 1'b1;
      EXECUTEI: begin
        ALUSrcB = SRCB_EXTIMM;
        ALUOp   = 1'b1;
      end
      ALUWB:    RegW = 1'b1;
      BRANCH: begin
        ALUSrcA   = SRCA_ALUOUT;
        ALUSrcB   = SRCB_EXTIMM;
        ResultSrc = RES_ALURESULT;
        Branch    = 1'b1;
      end
      FPUEXEC:  FPUStart = (count == '0);
      FPUWB: begin
        ResultSrc = RES_FPU;
        FPUW      = 1'b1;
      end
      default: ;
    endcase
  end

  assign State = state;

endmodule
